// File: rtl/battle_pkg.sv
// Shared board constants, coordinate type and shooter FSM states for battle_shooter.
package battle_pkg;

    typedef logic [3:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } shooter_state_t;

    localparam int unsigned BOARD_MAX        = 10;
    localparam int unsigned TOTAL_SHIP_CELLS = 19;
    localparam int unsigned BIG_BOMBS_INIT   = 2;
    localparam int unsigned MAX_SHOTS        = 100;

    localparam int unsigned HITS_W  = 5;
    localparam int unsigned SHOTS_W = 7;

endpackage

// File: rtl/battle_coord_step.sv
// Combinational scan-order step: X runs 1..10, then wraps to 1 on the next row.
module battle_coord_step
    import battle_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [3:0] next_x,
    output logic [3:0] next_y,
    output logic       last
);

    always_comb begin
        next_x = x + 4'(1);
        next_y = y;
        last   = (x == 4'(BOARD_MAX)) && (y == 4'(BOARD_MAX));
        if (x == 4'(BOARD_MAX)) begin
            next_x = 4'(1);
            next_y = last ? 4'(1) : y + 4'(1);
        end
    end

endmodule

// File: rtl/battle_shooter.sv
// Sequential shot initiator: sweeps the board one shot at a time and accumulates hits.
// Big-bomb policy is built only when SHOOTER_BIG_EN is defined.
module battle_shooter
    import battle_pkg::*;
(
    input  logic       clock,
    input  logic       reset_L,
    input  logic       start,
    output logic [3:0] X,
    output logic [3:0] Y,
    output logic       Big,
    output logic [1:0] BigLeft,
    output logic       ScoreThis,
    input  logic       shot_ready,
    input  logic       result_valid,
    input  logic [3:0] hit_count,
    input  logic       near_miss,
    output logic [4:0] total_hits,
    output logic [6:0] shots_fired,
    output logic       done
);

    shooter_state_t state_q, state_d;

    logic [3:0] next_x, next_y;
    logic       last;
    logic [5:0] hits_raw;
    logic [4:0] hits_sat;
    logic       start_game, accept, take_result, finish;

    battle_coord_step u_step (
        .x      (X),
        .y      (Y),
        .next_x (next_x),
        .next_y (next_y),
        .last   (last)
    );

    assign start_game  = start && ((state_q == IDLE) || (state_q == DONE));
    assign accept      = (state_q == ISSUE) && shot_ready;
    assign take_result = (state_q == WAIT) && result_valid;

    // Saturating hit accumulation; finish decision uses the post-update total.
    assign hits_raw = 6'(total_hits) + 6'(hit_count);
    assign hits_sat = (hits_raw > 6'(31)) ? 5'(31) : hits_raw[4:0];
    assign finish   = (hits_sat >= 5'(TOTAL_SHIP_CELLS))
                   || (shots_fired == 7'(MAX_SHOTS)) || last;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start)        state_d = ISSUE;
            ISSUE:      if (shot_ready)   state_d = WAIT;
            WAIT:       if (result_valid) state_d = finish ? DONE : ISSUE;
            default:                      state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            X           <= '0;
            Y           <= '0;
            total_hits  <= '0;
            shots_fired <= '0;
            ScoreThis   <= 1'b0;
            done        <= 1'b0;
        end else begin
            ScoreThis <= (state_d == ISSUE);
            done      <= (state_d == DONE);
            if (start_game) begin
                X           <= 4'(1);
                Y           <= 4'(1);
                total_hits  <= '0;
                shots_fired <= '0;
            end
            if (accept) shots_fired <= shots_fired + 7'(1);
            if (take_result) begin
                total_hits <= hits_sat;
                X          <= next_x;
                Y          <= next_y;
            end
        end
    end

`ifdef SHOOTER_BIG_EN
    logic [1:0] big_left, big_left_d;
    logic       arm_big, arm_big_d;

    always_comb begin
        arm_big_d  = arm_big;
        big_left_d = big_left;
        if (start_game) begin
            arm_big_d  = 1'b0;
            big_left_d = 2'(BIG_BOMBS_INIT);
        end else if (accept) begin
            arm_big_d = 1'b0;
            if (Big) big_left_d = big_left - 2'(1);
        end else if (take_result) begin
            arm_big_d = near_miss;
        end
    end

    // Big is decided on entry to ISSUE and holds until the handshake.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            big_left <= '0;
            arm_big  <= 1'b0;
            Big      <= 1'b0;
        end else begin
            big_left <= big_left_d;
            arm_big  <= arm_big_d;
            Big      <= (state_d == ISSUE) && arm_big_d && (big_left_d != 2'(0));
        end
    end

    assign BigLeft = big_left;
`else
    logic unused_near_miss;
    assign unused_near_miss = near_miss;
    assign Big              = 1'b0;
    assign BigLeft          = 2'b00;
`endif

endmodule

// File: tb/tb_battle_shooter.sv
// Scoreboard bench for battle_shooter: expected shots are queued, a negedge monitor checks each handshake.
module tb_battle_shooter;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic       big;
        logic [1:0] bl;
    } shot_t;

`ifdef SHOOTER_BIG_EN
    localparam bit BIG_EN = 1'b1;
`else
    localparam bit BIG_EN = 1'b0;
`endif

    logic       clock, reset_L, start;
    logic [3:0] X, Y;
    logic       Big;
    logic [1:0] BigLeft;
    logic       ScoreThis, shot_ready, result_valid, near_miss, done;
    logic [3:0] hit_count;
    logic [4:0] total_hits;
    logic [6:0] shots_fired;

    shot_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    battle_shooter dut (
        .clock        (clock),
        .reset_L      (reset_L),
        .start        (start),
        .X            (X),
        .Y            (Y),
        .Big          (Big),
        .BigLeft      (BigLeft),
        .ScoreThis    (ScoreThis),
        .shot_ready   (shot_ready),
        .result_valid (result_valid),
        .hit_count    (hit_count),
        .near_miss    (near_miss),
        .total_hits   (total_hits),
        .shots_fired  (shots_fired),
        .done         (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic shot_t mk(input int n, input bit big, input int bl);
        shot_t s;
        s.x   = 4'(n % 10 + 1);
        s.y   = 4'(n / 10 + 1);
        s.big = BIG_EN ? big : 1'b0;
        s.bl  = BIG_EN ? 2'(bl) : 2'b00;
        return s;
    endfunction

    // Monitor: every accepted shot must match the head of the expectation queue.
    always @(negedge clock) begin
        if (reset_L === 1'b1 && ScoreThis === 1'b1 && shot_ready === 1'b1) begin
            shot_t got, e;
            got = {X, Y, Big, BigLeft};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL shot_unexpected: got %0h expected none", got);
            end else begin
                e = exp_q.pop_front();
                check("shot", 32'(got), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_latency", 32'(ScoreThis), 32'(1));
    endtask

    task automatic wait_issue();
        int n = 0;
        while (ScoreThis !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (ScoreThis !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got ScoreThis=%b expected 1", ScoreThis);
        end
    endtask

    task automatic do_shot(input int stall, input logic [3:0] hc, input logic nm);
        logic [10:0] held;
        wait_issue();
        held = {X, Y, Big, BigLeft};
        for (int i = 0; i < stall; i++) begin
            tick();
            check("hold_stable", 32'({ScoreThis, X, Y, Big, BigLeft}), 32'({1'b1, held}));
        end
        shot_ready = 1'b1;
        tick();
        shot_ready   = 1'b0;
        result_valid = 1'b1;
        hit_count    = hc;
        near_miss    = nm;
        tick();
        result_valid = 1'b0;
        hit_count    = '0;
        near_miss    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 32'({X, Y, Big, BigLeft, ScoreThis, total_hits, shots_fired, done}), 32'(0));
    endtask

    initial begin
        start        = 1'b0;
        shot_ready   = 1'b0;
        result_valid = 1'b0;
        hit_count    = '0;
        near_miss    = 1'b0;
        reset_L      = 1'b0;
        repeat (3) tick();
        check("rst_X", 32'(X), 32'(0));
        check("rst_Y", 32'(Y), 32'(0));
        check("rst_Big", 32'(Big), 32'(0));
        check("rst_BigLeft", 32'(BigLeft), 32'(0));
        check("rst_ScoreThis", 32'(ScoreThis), 32'(0));
        check("rst_total_hits", 32'(total_hits), 32'(0));
        check("rst_shots_fired", 32'(shots_fired), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        reset_L = 1'b1;
        tick();
        check("idle_quiet", 32'(ScoreThis), 32'(0));

        // Full sweep with no hits: 100 shots in scan order.
        for (int i = 0; i < 100; i++) exp_q.push_back(mk(i, 1'b0, 2));
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            do_shot(0, 4'd0, 1'b0);
            if (i < 99) check("sweep_next_issue", 32'({done, ScoreThis}), 32'(1));
        end
        check("sweep_done", 32'(done), 32'(1));
        check("sweep_total", 32'(total_hits), 32'(0));
        check("sweep_shots", 32'(shots_fired), 32'(100));
        check("sweep_queue", 32'(exp_q.size()), 32'(0));
        repeat (3) begin
            tick();
            check("done_quiet", 32'({done, ScoreThis}), 32'(2));
        end

        // Restart from DONE: one hit on every second shot, done after the 19th hit.
        for (int i = 0; i < 38; i++) exp_q.push_back(mk(i, 1'b0, 2));
        pulse_start();
        for (int i = 0; i < 38; i++) begin
            do_shot(0, (i % 2 == 1) ? 4'd1 : 4'd0, 1'b0);
            if (i < 37) check("hits_not_done", 32'(done), 32'(0));
        end
        check("hits_done", 32'(done), 32'(1));
        check("hits_total", 32'(total_hits), 32'(19));
        check("hits_shots", 32'(shots_fired), 32'(38));
        check("hits_queue", 32'(exp_q.size()), 32'(0));
        tick();
        check("hits_quiet", 32'(ScoreThis), 32'(0));

        // Big bombs after near-misses, a stalled handshake, ignored inputs, mid-WAIT reset.
        exp_q.push_back(mk(0, 1'b0, 2));
        exp_q.push_back(mk(1, 1'b1, 2));
        exp_q.push_back(mk(2, 1'b1, 1));
        exp_q.push_back(mk(3, 1'b0, 0));
        exp_q.push_back(mk(4, 1'b0, 0));
        exp_q.push_back(mk(5, 1'b0, 0));
        pulse_start();
        do_shot(0, 4'd0, 1'b1);
        do_shot(5, 4'd0, 1'b1);
        check("stall_shots_once", 32'(shots_fired), 32'(2));
        do_shot(0, 4'd0, 1'b1);
        do_shot(0, 4'd3, 1'b0);

        wait_issue();
        result_valid = 1'b1;
        hit_count    = 4'd5;
        tick();
        result_valid = 1'b0;
        hit_count    = '0;
        check("rv_in_issue_state", 32'({ScoreThis, X, Y}), 32'({1'b1, 4'd5, 4'd1}));
        check("rv_in_issue_counts", 32'({total_hits, shots_fired}), 32'({5'd3, 7'd4}));
        shot_ready = 1'b1;
        tick();
        shot_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_wait_state", 32'({ScoreThis, X, Y}), 32'({1'b0, 4'd5, 4'd1}));
        check("start_in_wait_counts", 32'({total_hits, shots_fired}), 32'({5'd3, 7'd5}));
        result_valid = 1'b1;
        hit_count    = 4'd4;
        tick();
        result_valid = 1'b0;
        hit_count    = '0;

        wait_issue();
        shot_ready = 1'b1;
        tick();
        shot_ready = 1'b0;
        check("pre_reset", 32'({ScoreThis, total_hits, shots_fired, X}),
              32'({1'b0, 5'd7, 7'd6, 4'd6}));
        check("pre_reset_queue", 32'(exp_q.size()), 32'(0));
        #2;
        reset_L = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        tick();
        tick();
        reset_L = 1'b1;
        tick();
        check_reset_outputs("after_release");

        exp_q.push_back(mk(0, 1'b0, 2));
        pulse_start();
        do_shot(0, 4'd2, 1'b0);
        check("restart_state", 32'({total_hits, shots_fired, X, Y}),
              32'({5'd2, 7'd1, 4'd2, 4'd1}));
        check("final_queue", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
